// File: rtl/cpu_pkg.sv
// Shared types for the execute stage: ALU opcodes, operand-B sources,
// NZCV bit positions and the execute-stage FSM states.
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_PASSB = 3'b000,
    ALU_MUL   = 3'b001,
    ALU_ADD   = 3'b010,
    ALU_SUB   = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_XOR   = 3'b110,
    ALU_RSVD  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_DB     = 2'b00,
    SRC_IMM12  = 2'b01,
    SRC_DADDR9 = 2'b10,
    SRC_LS     = 2'b11
  } alu_src_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    EX_IDLE = 2'b00,
    EX_BUSY = 2'b01,
    EX_DONE = 2'b10
  } ex_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle. master drives the decoded instruction,
// slave (the execute stage) returns stall, flags and the EX/MEM register.
interface ex_stage_if #(parameter int WIDTH = 64);

  logic             valid_in;
  logic             flush;
  logic             RegWrite;
  logic             MemWrite;
  logic             MemToReg;
  logic             flagWrite;
  logic [1:0]       ALUSrc;
  logic [2:0]       ALUOp;
  logic [4:0]       Rd;
  logic [WIDTH-1:0] Da;
  logic [WIDTH-1:0] Db;
  logic [WIDTH-1:0] Imm12Ext;
  logic [WIDTH-1:0] Daddr9Ext;
  logic [WIDTH-1:0] LS;

  logic             stall;
  logic             valid_out;
  logic             RegWrite_out;
  logic             MemWrite_out;
  logic             MemToReg_out;
  logic [4:0]       Rd_out;
  logic [WIDTH-1:0] ALUResult_out;
  logic [WIDTH-1:0] StoreData_out;
  logic [3:0]       flags;

  modport master (
    output valid_in, flush, RegWrite, MemWrite, MemToReg, flagWrite,
           ALUSrc, ALUOp, Rd, Da, Db, Imm12Ext, Daddr9Ext, LS,
    input  stall, valid_out, RegWrite_out, MemWrite_out, MemToReg_out,
           Rd_out, ALUResult_out, StoreData_out, flags
  );

  modport slave (
    input  valid_in, flush, RegWrite, MemWrite, MemToReg, flagWrite,
           ALUSrc, ALUOp, Rd, Da, Db, Imm12Ext, Daddr9Ext, LS,
    output stall, valid_out, RegWrite_out, MemWrite_out, MemToReg_out,
           Rd_out, ALUResult_out, StoreData_out, flags
  );

endinterface

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BITS_PER_CYC multiplier bits
// per cycle; keeps only the low WIDTH bits of the product.
module mul_iter #(
  parameter int WIDTH            = 64,
  parameter int MUL_BITS_PER_CYC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int N  = WIDTH / MUL_BITS_PER_CYC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CW-1:0]    count_reg;
  logic             busy_reg;
  logic             last_step;
  logic [WIDTH-1:0] step_sum;
  logic [WIDTH-1:0] pp [MUL_BITS_PER_CYC];

  genvar gi;
  generate
    for (gi = 0; gi < MUL_BITS_PER_CYC; gi++) begin : g_pp
      assign pp[gi] = b_reg[gi] ? (a_reg << gi) : '0;
    end
  endgenerate

  always_comb begin
    step_sum = '0;
    for (int i = 0; i < MUL_BITS_PER_CYC; i++) begin
      step_sum = step_sum + pp[i];
    end
  end

  // done marks the final step; product holds the full result from the next cycle on
  assign last_step = busy_reg && (count_reg == CW'(N - 1));
  assign done      = last_step;
  assign busy      = busy_reg;
  assign product   = acc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
    end else if (abort) begin
      busy_reg  <= 1'b0;
    end else if (start) begin
      a_reg     <= a;
      b_reg     <= b;
      acc_reg   <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b1;
    end else if (busy_reg) begin
      acc_reg   <= acc_reg + step_sum;
      a_reg     <= a_reg << MUL_BITS_PER_CYC;
      b_reg     <= b_reg >> MUL_BITS_PER_CYC;
      count_reg <= count_reg + CW'(1);
      if (last_step) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand-B select, ALU with NZCV register, iterative MUL
// sequencing with ID/EX stall, and the registered EX/MEM bundle.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH            = 64,
  parameter int MUL_BITS_PER_CYC = 4
) (
  input logic       clk,
  input logic       reset,
  ex_stage_if.slave bus
);

  ex_state_e        state_reg;
  alu_op_e          op;
  logic             is_mul;
  logic             mul_start;
  logic             flag_load;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             c_flag;
  logic             v_flag;
  logic [3:0]       nzcv;

  logic             valid_out_reg;
  logic             rw_out_reg;
  logic             mw_out_reg;
  logic             m2r_out_reg;
  logic [4:0]       rd_out_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] store_reg;
  logic [3:0]       flags_reg;

  logic             hold_rw_reg;
  logic             hold_mw_reg;
  logic             hold_m2r_reg;
  logic [4:0]       hold_rd_reg;
  logic [WIDTH-1:0] hold_db_reg;

  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign op        = alu_op_e'(bus.ALUOp);
  assign is_mul    = (op == ALU_MUL);
  assign mul_start = (state_reg == EX_IDLE) && bus.valid_in && is_mul && !bus.flush;
  assign flag_load = (state_reg == EX_IDLE) && bus.valid_in && bus.flagWrite
                     && !bus.flush && !is_mul;
  // Gated by reset so the ID/EX hold drops the moment reset asserts
  assign bus.stall = reset && (mul_start || ((state_reg == EX_BUSY) && !bus.flush));

  always_comb begin
    b_sel = bus.Db;
    case (alu_src_e'(bus.ALUSrc))
      SRC_DB:     b_sel = bus.Db;
      SRC_IMM12:  b_sel = bus.Imm12Ext;
      SRC_DADDR9: b_sel = bus.Daddr9Ext;
      SRC_LS:     b_sel = bus.LS;
      default:    b_sel = bus.Db;
    endcase
  end

  always_comb begin
    b_eff   = (op == ALU_SUB) ? ~b_sel : b_sel;
    sum     = {1'b0, bus.Da} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == ALU_SUB)};
    alu_res = b_sel;
    c_flag  = 1'b0;
    v_flag  = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        alu_res = sum[WIDTH-1:0];
        c_flag  = sum[WIDTH];
        v_flag  = (bus.Da[WIDTH-1] == b_eff[WIDTH-1]) && (alu_res[WIDTH-1] != bus.Da[WIDTH-1]);
      end
      ALU_AND: alu_res = bus.Da & b_sel;
      ALU_OR:  alu_res = bus.Da | b_sel;
      ALU_XOR: alu_res = bus.Da ^ b_sel;
      default: alu_res = b_sel;
    endcase
    nzcv         = '0;
    nzcv[FLAG_N] = alu_res[WIDTH-1];
    nzcv[FLAG_Z] = (alu_res == '0);
    nzcv[FLAG_C] = c_flag;
    nzcv[FLAG_V] = v_flag;
  end

  mul_iter #(
    .WIDTH            (WIDTH),
    .MUL_BITS_PER_CYC (MUL_BITS_PER_CYC)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .abort   (bus.flush),
    .a       (bus.Da),
    .b       (b_sel),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= EX_IDLE;
      valid_out_reg <= 1'b0;
      rw_out_reg    <= 1'b0;
      mw_out_reg    <= 1'b0;
      m2r_out_reg   <= 1'b0;
      rd_out_reg    <= '0;
      result_reg    <= '0;
      store_reg     <= '0;
      flags_reg     <= '0;
      hold_rw_reg   <= 1'b0;
      hold_mw_reg   <= 1'b0;
      hold_m2r_reg  <= 1'b0;
      hold_rd_reg   <= '0;
      hold_db_reg   <= '0;
    end else begin
      // Bubble by default; the branches below overwrite it when something issues
      valid_out_reg <= 1'b0;
      rw_out_reg    <= 1'b0;
      mw_out_reg    <= 1'b0;
      m2r_out_reg   <= 1'b0;
      if (bus.flush) begin
        state_reg <= EX_IDLE;
      end else begin
        case (state_reg)
          EX_IDLE: begin
            if (bus.valid_in && is_mul) begin
              hold_rw_reg  <= bus.RegWrite;
              hold_mw_reg  <= bus.MemWrite;
              hold_m2r_reg <= bus.MemToReg;
              hold_rd_reg  <= bus.Rd;
              hold_db_reg  <= bus.Db;
              state_reg    <= EX_BUSY;
            end else if (bus.valid_in) begin
              valid_out_reg <= 1'b1;
              rw_out_reg    <= bus.RegWrite;
              mw_out_reg    <= bus.MemWrite;
              m2r_out_reg   <= bus.MemToReg;
              rd_out_reg    <= bus.Rd;
              result_reg    <= alu_res;
              store_reg     <= bus.Db;
            end
          end
          EX_BUSY: begin
            if (mul_done) begin
              state_reg <= EX_DONE;
            end else if (!mul_busy) begin
              state_reg <= EX_IDLE;
            end
          end
          EX_DONE: begin
            valid_out_reg <= 1'b1;
            rw_out_reg    <= hold_rw_reg;
            mw_out_reg    <= hold_mw_reg;
            m2r_out_reg   <= hold_m2r_reg;
            rd_out_reg    <= hold_rd_reg;
            result_reg    <= mul_product;
            store_reg     <= hold_db_reg;
            state_reg     <= EX_IDLE;
          end
          default: state_reg <= EX_IDLE;
        endcase
      end
      if (flag_load) begin
        flags_reg <= nzcv;
      end
    end
  end

  assign bus.valid_out     = valid_out_reg;
  assign bus.RegWrite_out  = rw_out_reg;
  assign bus.MemWrite_out  = mw_out_reg;
  assign bus.MemToReg_out  = m2r_out_reg;
  assign bus.Rd_out        = rd_out_reg;
  assign bus.ALUResult_out = result_reg;
  assign bus.StoreData_out = store_reg;
  assign bus.flags         = flags_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized bench for ex_stage against a plain-arithmetic
// reference model of the ALU, flags and MUL timing.
module tb_ex_stage;

  localparam int W = 64;
  localparam logic signed [65:0] SMAX = (66'sd1 <<< 63) - 66'sd1;
  localparam logic signed [65:0] SMIN = -(66'sd1 <<< 63);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] exp_flags = 4'b0000;

  always #5 clk = ~clk;

  ex_stage_if #(.WIDTH(W)) bus ();

  ex_stage #(
    .WIDTH            (W),
    .MUL_BITS_PER_CYC (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pick_b();
    case (bus.ALUSrc)
      2'b00:   return bus.Db;
      2'b01:   return bus.Imm12Ext;
      2'b10:   return bus.Daddr9Ext;
      default: return bus.LS;
    endcase
  endfunction

  // Reference ALU: true-value arithmetic, carries/overflow from range checks
  function automatic void model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] res, output logic [3:0] f);
    logic c, v;
    logic signed [65:0] sa, sb, t;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd1: res = a * b;
      3'd2: begin res = a + b; c = (res < a);  t = sa + sb; v = (t > SMAX) || (t < SMIN); end
      3'd3: begin res = a - b; c = (a >= b);   t = sa - sb; v = (t > SMAX) || (t < SMIN); end
      3'd4: res = a & b;
      3'd5: res = a | b;
      3'd6: res = a ^ b;
      default: res = b;
    endcase
    f = {res[63], (res == 64'd0), c, v};
  endfunction

  task automatic clear_inputs();
    bus.valid_in  = 1'b0;
    bus.flush     = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.MemToReg  = 1'b0;
    bus.flagWrite = 1'b0;
    bus.ALUSrc    = 2'b00;
    bus.ALUOp     = 3'b000;
    bus.Rd        = 5'd0;
    bus.Da        = '0;
    bus.Db        = '0;
    bus.Imm12Ext  = '0;
    bus.Daddr9Ext = '0;
    bus.LS        = '0;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [1:0] src, input logic [63:0] a,
                        input logic [63:0] b, input logic fw, input logic [4:0] rd);
    bus.valid_in  = 1'b1;
    bus.flush     = 1'b0;
    bus.ALUOp     = op;
    bus.ALUSrc    = src;
    bus.Da        = a;
    bus.Db        = {$urandom, $urandom};
    bus.Imm12Ext  = {$urandom, $urandom};
    bus.Daddr9Ext = {$urandom, $urandom};
    bus.LS        = {$urandom, $urandom};
    case (src)
      2'b00:   bus.Db        = b;
      2'b01:   bus.Imm12Ext  = b;
      2'b10:   bus.Daddr9Ext = b;
      default: bus.LS        = b;
    endcase
    bus.flagWrite = fw;
    bus.Rd        = rd;
    bus.RegWrite  = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.MemToReg  = 1'b0;
  endtask

  task automatic issue_alu(input string tag);
    logic [63:0] res;
    logic [3:0]  f;
    #1;
    model(bus.ALUOp, bus.Da, pick_b(), res, f);
    if (bus.flagWrite) exp_flags = f;
    chk({tag, " stall"}, bus.stall, 64'd0);
    tick();
    chk({tag, " valid_out"}, bus.valid_out, 64'd1);
    chk({tag, " result"}, bus.ALUResult_out, res);
    chk({tag, " rd"}, bus.Rd_out, bus.Rd);
    chk({tag, " ctl"}, {bus.RegWrite_out, bus.MemWrite_out, bus.MemToReg_out},
        {bus.RegWrite, bus.MemWrite, bus.MemToReg});
    chk({tag, " store"}, bus.StoreData_out, bus.Db);
    chk({tag, " flags"}, bus.flags, exp_flags);
    $display("txn %s op=%0d res=%h flags=%b", tag, bus.ALUOp, bus.ALUResult_out, bus.flags);
  endtask

  task automatic issue_mul(input string tag);
    logic [63:0] res;
    logic [3:0]  f;
    int stall_cnt;
    int bubbles;
    #1;
    model(3'd1, bus.Da, pick_b(), res, f);
    stall_cnt = 0;
    bubbles   = 0;
    chk({tag, " stall start"}, bus.stall, 64'd1);
    while (bus.stall === 1'b1 && stall_cnt < 40) begin
      stall_cnt++;
      tick();
      if (bus.stall === 1'b1 && bus.valid_out === 1'b0) bubbles++;
    end
    chk({tag, " stall cycles"}, 64'(stall_cnt), 64'd17);
    chk({tag, " bubbles"}, 64'(bubbles), 64'd16);
    chk({tag, " done bubble"}, bus.valid_out, 64'd0);
    tick();
    chk({tag, " valid_out"}, bus.valid_out, 64'd1);
    chk({tag, " product"}, bus.ALUResult_out, res);
    chk({tag, " rd"}, bus.Rd_out, bus.Rd);
    chk({tag, " store"}, bus.StoreData_out, bus.Db);
    chk({tag, " flags"}, bus.flags, exp_flags);
    $display("txn %s MUL res=%h stall=%0d", tag, bus.ALUResult_out, stall_cnt);
    bus.valid_in = 1'b0;
    #1;
    chk({tag, " no restart"}, bus.stall, 64'd0);
    tick();
    chk({tag, " single issue"}, bus.valid_out, 64'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [1:0]  src;
    logic [63:0] a, b;
    int          kind;

    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_out", bus.valid_out, 64'd0);
    chk("reset result", bus.ALUResult_out, 64'd0);
    chk("reset store", {bus.StoreData_out}, 64'd0);
    chk("reset flags", bus.flags, 64'd0);
    chk("reset stall", bus.stall, 64'd0);
    reset = 1'b1;
    tick();

    set_op(3'd2, 2'b01, 64'd5, -64'sd5, 1'b1, 5'd1);
    issue_alu("add_zero");
    chk("add_zero nzcv", bus.flags, 64'b0110);

    set_op(3'd3, 2'b00, 64'd3, 64'd5, 1'b1, 5'd2);
    issue_alu("sub_neg");
    chk("sub_neg value", bus.ALUResult_out, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_neg nzcv", bus.flags, 64'b1000);

    set_op(3'd2, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 5'd3);
    issue_alu("add_ovf");
    chk("add_ovf nzcv", bus.flags, 64'b1001);

    set_op(3'd4, 2'b11, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 5'd4);
    issue_alu("and_nofw");
    chk("and_nofw nzcv", bus.flags, 64'b1001);

    set_op(3'd1, 2'b00, 64'd7, 64'd6, 1'b1, 5'd5);
    issue_mul("mul_7x6");
    chk("mul_7x6 value", bus.ALUResult_out, 64'd42);

    // Flush on the 5th BUSY cycle, then a normal ADD
    set_op(3'd1, 2'b00, 64'd11, 64'd13, 1'b0, 5'd6);
    #1;
    chk("flush stall start", bus.stall, 64'd1);
    repeat (5) tick();
    bus.flush = 1'b1;
    #1;
    chk("flush stall drop", bus.stall, 64'd0);
    tick();
    chk("flush bubble", bus.valid_out, 64'd0);
    chk("flush rw", bus.RegWrite_out, 64'd0);
    set_op(3'd2, 2'b00, 64'd100, 64'd23, 1'b1, 5'd7);
    issue_alu("post_flush_add");
    bus.valid_in = 1'b0;
    repeat (20) begin
      tick();
      if (bus.valid_out !== 1'b0) break;
    end
    chk("no stray product", bus.valid_out, 64'd0);

    for (int i = 0; i < 40; i++) begin
      op   = 3'($urandom_range(0, 7));
      src  = 2'($urandom_range(0, 3));
      a    = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
      b    = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
      kind = $urandom_range(0, 9);
      set_op(op, src, a, b, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      bus.MemWrite = 1'($urandom_range(0, 1));
      bus.MemToReg = 1'($urandom_range(0, 1));
      if (kind == 0 || kind == 1) begin
        if (kind == 0) bus.valid_in = 1'b0;
        else           bus.flush    = 1'b1;
        #1;
        chk("rand bubble stall", bus.stall, 64'd0);
        tick();
        chk("rand bubble valid", bus.valid_out, 64'd0);
        chk("rand bubble ctl", {bus.RegWrite_out, bus.MemWrite_out, bus.MemToReg_out}, 64'd0);
        chk("rand bubble flags", bus.flags, exp_flags);
        $display("txn rand bubble kind=%0d", kind);
        bus.flush = 1'b0;
      end else if (op == 3'd1) begin
        issue_mul("rand_mul");
      end else begin
        issue_alu("rand_alu");
      end
    end

    // Asynchronous reset between edges while a MUL is in flight
    set_op(3'd1, 2'b00, 64'd9, 64'd9, 1'b0, 5'd8);
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("midreset valid_out", bus.valid_out, 64'd0);
    chk("midreset result", bus.ALUResult_out, 64'd0);
    chk("midreset rd", bus.Rd_out, 64'd0);
    chk("midreset flags", bus.flags, 64'd0);
    chk("midreset stall", bus.stall, 64'd0);
    exp_flags = 4'b0000;
    bus.valid_in = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("post reset idle", bus.valid_out, 64'd0);
    set_op(3'd2, 2'b10, 64'h1000, 64'h10, 1'b0, 5'd9);
    bus.RegWrite = 1'b1;
    bus.MemToReg = 1'b1;
    issue_alu("ldur_addr");
    chk("ldur_addr value", bus.ALUResult_out, 64'h1010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
